regfile_wb_arbiter: RTL and testbench

//  Writer side of the physical register file: collects completed results from NUM_SRC producers.

---
 rtl/regfile_wb_arbiter.sv | 143 ++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the physical register file: buffers producer results in
// per-source FIFOs and grants up to WRITE_PORTS heads per cycle in round-robin order.

`ifndef PHYS_REG_SZ_R10K
`define PHYS_REG_SZ_R10K 64
`endif

module regfile_wb_arbiter #(
  parameter  int NUM_SRC     = 4,
  parameter  int WRITE_PORTS = 2,
  parameter  int BUF_DEPTH   = 2,
  parameter  int DEPTH       = `PHYS_REG_SZ_R10K,
  parameter  int DATA_W      = 32,
  localparam int TAG_W       = $clog2(DEPTH),
  localparam int OCC_W       = $clog2(NUM_SRC*BUF_DEPTH+1)
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic [NUM_SRC-1:0]                  src_valid,
  output logic [NUM_SRC-1:0]                  src_ready,
  input  logic [NUM_SRC-1:0][TAG_W-1:0]       src_tag,
  input  logic [NUM_SRC-1:0][DATA_W-1:0]      src_data,
  input  logic                                wb_stall,
  output logic [WRITE_PORTS-1:0]              we,
  output logic [WRITE_PORTS-1:0][TAG_W-1:0]   waddr,
  output logic [WRITE_PORTS-1:0][DATA_W-1:0]  wdata,
  output logic [OCC_W-1:0]                    occ
);

  localparam int ADDR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W  = $clog2(BUF_DEPTH+1);
  localparam int PTR_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [TAG_W-1:0]  buf_tag  [NUM_SRC][BUF_DEPTH];
  logic [DATA_W-1:0] buf_data [NUM_SRC][BUF_DEPTH];
  logic [ADDR_W-1:0] rd_ptr   [NUM_SRC];
  logic [ADDR_W-1:0] wr_ptr   [NUM_SRC];
  logic [CNT_W-1:0]  count    [NUM_SRC];
  logic [PTR_W-1:0]  rr_ptr;
  logic [PTR_W-1:0]  rr_next;
  logic [NUM_SRC-1:0] push;
  logic [NUM_SRC-1:0] pop;
  logic [OCC_W-1:0]  n_push;
  logic [OCC_W-1:0]  n_pop;

  function automatic logic [ADDR_W-1:0] next_ptr(input logic [ADDR_W-1:0] p);
    return (p == ADDR_W'(BUF_DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  // Readiness comes only from the registered count, so a full FIFO stays closed while it drains
  always_comb begin
    src_ready = '0;
    push      = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      src_ready[i] = !reset && (count[i] < CNT_W'(BUF_DEPTH));
      push[i]      = src_valid[i] && src_ready[i];
    end
  end

  // Round-robin scan from rr_ptr; a head whose tag clashes with an earlier grant waits a cycle
  always_comb begin
    int   n_grant;
    int   idx;
    logic clash;
    we      = '0;
    waddr   = '0;
    wdata   = '0;
    pop     = '0;
    rr_next = rr_ptr;
    n_grant = 0;
    idx     = 0;
    clash   = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      idx   = (int'(rr_ptr) + k) % NUM_SRC;
      clash = 1'b0;
      for (int p = 0; p < WRITE_PORTS; p++) begin
        if (p < n_grant && waddr[p] == buf_tag[idx][rd_ptr[idx]]) clash = 1'b1;
      end
      if (!wb_stall && count[idx] != '0 && n_grant < WRITE_PORTS && !clash) begin
        we[n_grant]    = 1'b1;
        waddr[n_grant] = buf_tag[idx][rd_ptr[idx]];
        wdata[n_grant] = buf_data[idx][rd_ptr[idx]];
        pop[idx]       = 1'b1;
        rr_next        = PTR_W'((idx + 1) % NUM_SRC);
        n_grant        = n_grant + 1;
      end
    end
  end

  always_comb begin
    n_push = OCC_W'($countones(push));
    n_pop  = OCC_W'($countones(pop));
  end

  // Payload storage needs no reset; validity is tracked by the pointers and counts
  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_SRC; i++) begin
      if (push[i]) begin
        buf_tag[i][wr_ptr[i]]  <= src_tag[i];
        buf_data[i][wr_ptr[i]] <= src_data[i];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rr_ptr <= '0;
      occ    <= '0;
      for (int i = 0; i < NUM_SRC; i++) begin
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
        count[i]  <= '0;
      end
    end else begin
      rr_ptr <= rr_next;
      occ    <= occ + n_push - n_pop;
      for (int i = 0; i < NUM_SRC; i++) begin
        if (push[i]) wr_ptr[i] <= next_ptr(wr_ptr[i]);
        if (pop[i])  rd_ptr[i] <= next_ptr(rd_ptr[i]);
        if (push[i] && !pop[i])      count[i] <= count[i] + 1'b1;
        else if (!push[i] && pop[i]) count[i] <= count[i] - 1'b1;
      end
    end
  end

`ifdef GEN_ASSERT
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (push[i]) assert (int'(src_tag[i]) < DEPTH) else $error("tag out of range");
        assert (!(push[i] && !pop[i] && count[i] == CNT_W'(BUF_DEPTH))) else $error("fifo overflow");
        assert (!(pop[i] && count[i] == '0)) else $error("fifo underflow");
      end
      for (int p = 0; p < WRITE_PORTS; p++) begin
        for (int q = p + 1; q < WRITE_PORTS; q++) begin
          assert (!(we[p] && we[q] && waddr[p] == waddr[q])) else $error("duplicate waddr");
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed, table-driven bench for regfile_wb_arbiter, plus hand-written
// sequences for mid-cycle reset and single-write-port fairness.

module tb_regfile_wb_arbiter;

  logic              clock = 1'b0;
  logic              reset;
  logic [3:0]        src_valid;
  logic [3:0]        src_ready;
  logic [3:0][5:0]   src_tag;
  logic [3:0][31:0]  src_data;
  logic              wb_stall;
  logic [1:0]        we;
  logic [1:0][5:0]   waddr;
  logic [1:0][31:0]  wdata;
  logic [3:0]        occ;

  logic [3:0]        v1_valid;
  logic [3:0]        v1_ready;
  logic [3:0][5:0]   v1_tag;
  logic [3:0][31:0]  v1_data;
  logic              v1_stall;
  logic [0:0]        v1_we;
  logic [0:0][5:0]   v1_waddr;
  logic [0:0][31:0]  v1_wdata;
  logic [3:0]        v1_occ;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  regfile_wb_arbiter #(.NUM_SRC(4), .WRITE_PORTS(2), .BUF_DEPTH(2), .DEPTH(64)) dut (
    .clock(clock), .reset(reset), .src_valid(src_valid), .src_ready(src_ready),
    .src_tag(src_tag), .src_data(src_data), .wb_stall(wb_stall),
    .we(we), .waddr(waddr), .wdata(wdata), .occ(occ)
  );

  regfile_wb_arbiter #(.NUM_SRC(4), .WRITE_PORTS(1), .BUF_DEPTH(2), .DEPTH(64)) dut1 (
    .clock(clock), .reset(reset), .src_valid(v1_valid), .src_ready(v1_ready),
    .src_tag(v1_tag), .src_data(v1_data), .wb_stall(v1_stall),
    .we(v1_we), .waddr(v1_waddr), .wdata(v1_wdata), .occ(v1_occ)
  );

  typedef struct {
    logic [3:0]       valid;
    logic [3:0][5:0]  tag;
    logic [3:0][31:0] data;
    logic             stall;
    logic [1:0]       exp_we;
    logic [1:0][5:0]  exp_waddr;
    logic [1:0][31:0] exp_wdata;
    logic [3:0]       exp_ready;
    logic [3:0]       exp_occ;
  } vec_t;

  localparam int NVEC = 17;
  vec_t vecs [NVEC];

  function automatic vec_t mk(input logic [3:0] valid, input logic [3:0][5:0] tag,
                              input logic [3:0][31:0] data, input logic stall,
                              input logic [1:0] ewe, input logic [1:0][5:0] ewaddr,
                              input logic [1:0][31:0] ewdata, input logic [3:0] eready,
                              input logic [3:0] eocc);
    vec_t v;
    v.valid = valid; v.tag = tag; v.data = data; v.stall = stall;
    v.exp_we = ewe; v.exp_waddr = ewaddr; v.exp_wdata = ewdata;
    v.exp_ready = eready; v.exp_occ = eocc;
    return v;
  endfunction

  task automatic check_output(input string name, input logic [127:0] actual,
                              input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic apply_stimulus(input vec_t v);
    src_valid = v.valid;
    src_tag   = v.tag;
    src_data  = v.data;
    wb_stall  = v.stall;
  endtask

  initial begin
    reset = 1'b1;
    src_valid = '0; src_tag = '0; src_data = '0; wb_stall = 1'b0;
    v1_valid = '0; v1_tag = '0; v1_data = '0; v1_stall = 1'b0;

    vecs[0]  = mk(4'b0010, {6'd0, 6'd0, 6'd5, 6'd0}, {32'h0, 32'h0, 32'hDEAD, 32'h0}, 1'b0,
                  2'b00, '0, '0, 4'b1111, 4'd0);
    vecs[1]  = mk(4'b0000, '0, '0, 1'b0,
                  2'b01, {6'd0, 6'd5}, {32'h0, 32'hDEAD}, 4'b1111, 4'd1);
    vecs[2]  = mk(4'b1000, {6'd9, 6'd0, 6'd0, 6'd0}, {32'h33, 32'h0, 32'h0, 32'h0}, 1'b0,
                  2'b00, '0, '0, 4'b1111, 4'd0);
    vecs[3]  = mk(4'b0000, '0, '0, 1'b0,
                  2'b01, {6'd0, 6'd9}, {32'h0, 32'h33}, 4'b1111, 4'd1);
    vecs[4]  = mk(4'b1111, {6'd13, 6'd12, 6'd11, 6'd10}, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 1'b0,
                  2'b00, '0, '0, 4'b1111, 4'd0);
    vecs[5]  = mk(4'b0000, '0, '0, 1'b0,
                  2'b11, {6'd11, 6'd10}, {32'hA1, 32'hA0}, 4'b1111, 4'd4);
    vecs[6]  = mk(4'b0000, '0, '0, 1'b0,
                  2'b11, {6'd13, 6'd12}, {32'hA3, 32'hA2}, 4'b1111, 4'd2);
    vecs[7]  = mk(4'b1001, {6'd7, 6'd0, 6'd0, 6'd7}, {32'h73, 32'h0, 32'h0, 32'h70}, 1'b0,
                  2'b00, '0, '0, 4'b1111, 4'd0);
    vecs[8]  = mk(4'b0000, '0, '0, 1'b0,
                  2'b01, {6'd0, 6'd7}, {32'h0, 32'h70}, 4'b1111, 4'd2);
    vecs[9]  = mk(4'b0000, '0, '0, 1'b0,
                  2'b01, {6'd0, 6'd7}, {32'h0, 32'h73}, 4'b1111, 4'd1);
    vecs[10] = mk(4'b0100, {6'd0, 6'd20, 6'd0, 6'd0}, {32'h0, 32'hC0, 32'h0, 32'h0}, 1'b1,
                  2'b00, '0, '0, 4'b1111, 4'd0);
    vecs[11] = mk(4'b0100, {6'd0, 6'd21, 6'd0, 6'd0}, {32'h0, 32'hC1, 32'h0, 32'h0}, 1'b1,
                  2'b00, '0, '0, 4'b1111, 4'd1);
    vecs[12] = mk(4'b0100, {6'd0, 6'd22, 6'd0, 6'd0}, {32'h0, 32'hC2, 32'h0, 32'h0}, 1'b1,
                  2'b00, '0, '0, 4'b1011, 4'd2);
    vecs[13] = mk(4'b0000, '0, '0, 1'b0,
                  2'b01, {6'd0, 6'd20}, {32'h0, 32'hC0}, 4'b1011, 4'd2);
    vecs[14] = mk(4'b0100, {6'd0, 6'd23, 6'd0, 6'd0}, {32'h0, 32'hC3, 32'h0, 32'h0}, 1'b0,
                  2'b01, {6'd0, 6'd21}, {32'h0, 32'hC1}, 4'b1111, 4'd1);
    vecs[15] = mk(4'b0000, '0, '0, 1'b0,
                  2'b01, {6'd0, 6'd23}, {32'h0, 32'hC3}, 4'b1111, 4'd1);
    vecs[16] = mk(4'b0000, '0, '0, 1'b0,
                  2'b00, '0, '0, 4'b1111, 4'd0);

    repeat (2) @(posedge clock);
    #1;
    check_output("reset_we",    128'(we),        128'(0));
    check_output("reset_waddr", 128'(waddr),     128'(0));
    check_output("reset_wdata", 128'(wdata),     128'(0));
    check_output("reset_ready", 128'(src_ready), 128'(0));
    check_output("reset_occ",   128'(occ),       128'(0));
    reset = 1'b0;

    for (int j = 0; j < NVEC; j++) begin
      apply_stimulus(vecs[j]);
      #1;
      check_output($sformatf("v%0d_we", j),    128'(we),        128'(vecs[j].exp_we));
      check_output($sformatf("v%0d_waddr", j), 128'(waddr),     128'(vecs[j].exp_waddr));
      check_output($sformatf("v%0d_wdata", j), 128'(wdata),     128'(vecs[j].exp_wdata));
      check_output($sformatf("v%0d_ready", j), 128'(src_ready), 128'(vecs[j].exp_ready));
      check_output($sformatf("v%0d_occ", j),   128'(occ),       128'(vecs[j].exp_occ));
      @(posedge clock);
      #1;
    end

    // Build occ=5 under stall, then reset in the middle of a granting cycle
    wb_stall  = 1'b1;
    src_valid = 4'b1111;
    src_tag   = {6'd33, 6'd32, 6'd31, 6'd30};
    src_data  = {32'hB3, 32'hB2, 32'hB1, 32'hB0};
    @(posedge clock); #1;
    src_valid = 4'b0001;
    src_tag   = {6'd0, 6'd0, 6'd0, 6'd34};
    @(posedge clock); #1;
    src_valid = '0;
    wb_stall  = 1'b0;
    #1;
    check_output("pre_reset_occ",   128'(occ),   128'(5));
    check_output("pre_reset_we",    128'(we),    128'(2'b11));
    check_output("pre_reset_waddr", 128'(waddr), 128'({6'd30, 6'd33}));
    #2;
    reset = 1'b1;
    #1;
    check_output("mid_reset_we",    128'(we),        128'(0));
    check_output("mid_reset_occ",   128'(occ),       128'(0));
    check_output("mid_reset_ready", 128'(src_ready), 128'(0));
    @(posedge clock); #1;
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      check_output($sformatf("post_reset%0d_we", c),  128'(we),        128'(0));
      check_output($sformatf("post_reset%0d_occ", c), 128'(occ),       128'(0));
      check_output($sformatf("post_reset%0d_rdy", c), 128'(src_ready), 128'(4'b1111));
      @(posedge clock); #1;
    end

    // Single write port: two always-valid sources must alternate
    v1_tag   = {6'd0, 6'd0, 6'd2, 6'd1};
    v1_data  = {32'h0, 32'h0, 32'h22, 32'h11};
    v1_valid = 4'b0011;
    for (int c = 0; c < 9; c++) begin
      #1;
      if (c == 0) begin
        check_output("wp1_c0_we", 128'(v1_we), 128'(0));
      end else begin
        check_output($sformatf("wp1_c%0d_we", c),    128'(v1_we),    128'(1));
        check_output($sformatf("wp1_c%0d_waddr", c), 128'(v1_waddr), 128'((c % 2 == 1) ? 1 : 2));
      end
      @(posedge clock); #1;
    end
    v1_valid = '0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
